vram_sram_model: RTL
====================

# vram_sram_model

Clocked behavioural model of the 8 KiB external video RAM that sits on the other end of the VRAM pin bus (MA[12:0], MD[7:0], /MCS, /MOE, /MWR) driven by the PPU/CPU VRAM interface. It samples the active-low strobes each clock, returns read data on MD after a fixed latency, commits writes on the trailing edge of the write strobe, and flags bus contention. It is the responder used by the system testbench and by standalone interface benches.

## Interface
Parameters:
- READ_LAT, 2: cycles from first sampled read condition to md_oe high (legal 1..7).
- FILL, 8'h00: value written to every location by the power-up sweep.
- INIT_EN, 1: 1 = run fill sweep after reset; 0 = skip it, array contents X.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- nreset  input  1  reset; synchronous, active-low.
- ma  input  13  address pins (pin level).
- md_in  input  8  data pins as driven by the interface (write data).
- md_out  output  8  read data driven onto MD when md_oe=1.
- md_oe  output  1  1 = model drives MD.
- mcs_n, moe_n, mwr_n  input  1 each  chip-select / output-enable / write-enable pins, active-low.
- init_busy  output  1  fill sweep in progress; bus ignored.
- wr_commit  output  1  one-cycle pulse when a write is stored.
- contention  output  1  sticky: /MOE and /MWR seen low together under /MCS.

## Operation
- Array: 8192 x 8. States INIT, IDLE, READ, WRITE.
- INIT (only if INIT_EN): 13-bit sweep counter from 0, writes FILL each cycle, 8192 cycles, then IDLE. Bus inputs ignored, md_oe=0, wr_commit=0 during INIT. INIT_EN=0: reset goes straight to IDLE.
- Conditions on sampled pins: RD = !mcs_n & !moe_n & mwr_n; WR = !mcs_n & !mwr_n.
- IDLE -> WRITE on WR (priority over RD); IDLE -> READ on RD.
- READ: latch ma as rd_addr on entry; latency counter counts READ_LAT cycles then md_oe=1, md_out=mem[rd_addr]. If ma differs from rd_addr while in READ: relatch, md_oe=0, restart latency. Leave to IDLE when RD false; md_oe=0 from that edge. WR seen during READ -> WRITE, md_oe=0.
- WRITE: each cycle capture wr_addr=ma, wr_data=md_in. When WR goes false (/MWR or /MCS high), store wr_data at wr_addr, pulse wr_commit, go IDLE (or READ if RD true that cycle, latency restarts). md_oe=0 throughout.
- Contention: !mcs_n & !moe_n & !mwr_n sampled -> contention=1 until reset; write behaviour unchanged, md_oe forced 0.
- /MCS high: no access regardless of /MOE, /MWR.

## Timing
- Reset values: md_oe=0, md_out=8'h00, wr_commit=0, contention=0, init_busy=INIT_EN, state INIT (or IDLE), sweep counter 0.
- nreset low mid-access: abort; captured write is NOT committed; sweep restarts at address 0.
- Read latency: RD sampled at edge N -> md_oe=1 and valid md_out after edge N+READ_LAT.
- Write: WR false sampled at edge M -> array updated and wr_commit=1 after edge M; a read of that address started at M sees new data.
- init_busy falls after edge 8192 following reset release; first access accepted at the next edge.
- Sweep counter wraps 8191->0 only at INIT exit; no other wrap.

## Test plan
- Reset, INIT_EN=1, FILL=8'hA5: init_busy high exactly 8192 cycles; then read 0x0000 and 0x1FFF -> md_out=8'hA5, md_oe high 2 cycles after RD.
- Write 8'h3C to 0x1234 (/MWR low 3 cycles): single wr_commit pulse on release; readback 0x1234 -> 8'h3C; 0x1233 still FILL.
- Read with ma changing 0x0010->0x0011 after 1 cycle: md_oe stays 0 until 2 cycles after change; data = mem[0x0011].
- /MOE and /MWR low together with /MCS low: contention=1 and stays 1, md_oe=0, write committed on release.
- nreset asserted while /MWR low on 0x0200 with 8'hFF: no wr_commit; after re-sweep 0x0200 reads FILL.
- /MCS high with /MOE, /MWR toggling: md_oe=0, no wr_commit, array unchanged.

Source files
------------

// File: rtl/vram_sram_model.sv
// Behavioural 8 KiB x 8 VRAM responder for the MA/MD pin bus.
// It optionally fills the array after reset, serves reads after a fixed latency, commits writes on strobe release and flags /MOE-/MWR contention.
module vram_sram_model #(
  parameter int         READ_LAT = 2,
  parameter logic [7:0] FILL     = 8'h00,
  parameter bit         INIT_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [12:0] ma,
  input  logic [7:0]  md_in,
  output logic [7:0]  md_out,
  output logic        md_oe,
  input  logic        mcs_n,
  input  logic        moe_n,
  input  logic        mwr_n,
  output logic        init_busy,
  output logic        wr_commit,
  output logic        contention
);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_READ, ST_WRITE} state_t;

  localparam logic [2:0] LAT = 3'(READ_LAT);

  logic [7:0]  mem [0:8191];

  state_t      state, state_nxt;
  logic [12:0] sweep_cnt, sweep_nxt;
  logic [12:0] rd_addr, rd_addr_nxt;
  logic [12:0] wr_addr, wr_addr_nxt;
  logic [7:0]  wr_data, wr_data_nxt;
  logic [2:0]  lat_cnt, lat_nxt;
  logic [7:0]  md_out_nxt;
  logic        md_oe_nxt, wr_commit_nxt, contention_nxt;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        rd_cond, wr_cond, clash;

  assign rd_cond   = !mcs_n && !moe_n && mwr_n;
  assign wr_cond   = !mcs_n && !mwr_n;
  assign clash     = !mcs_n && !moe_n && !mwr_n;
  assign init_busy = (state == ST_INIT);

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state      <= INIT_EN ? ST_INIT : ST_IDLE;
      sweep_cnt  <= '0;
      rd_addr    <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      lat_cnt    <= '0;
      md_out     <= 8'h00;
      md_oe      <= 1'b0;
      wr_commit  <= 1'b0;
      contention <= 1'b0;
    end else begin
      state      <= state_nxt;
      sweep_cnt  <= sweep_nxt;
      rd_addr    <= rd_addr_nxt;
      wr_addr    <= wr_addr_nxt;
      wr_data    <= wr_data_nxt;
      lat_cnt    <= lat_nxt;
      md_out     <= md_out_nxt;
      md_oe      <= md_oe_nxt;
      wr_commit  <= wr_commit_nxt;
      contention <= contention_nxt;
    end
  end

  // Array has a single write port shared by the fill sweep and write commits.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_comb begin
    state_nxt      = state;
    sweep_nxt      = sweep_cnt;
    rd_addr_nxt    = rd_addr;
    wr_addr_nxt    = wr_addr;
    wr_data_nxt    = wr_data;
    lat_nxt        = lat_cnt;
    md_out_nxt     = md_out;
    md_oe_nxt      = 1'b0;
    wr_commit_nxt  = 1'b0;
    contention_nxt = contention;
    mem_we         = 1'b0;
    mem_addr       = sweep_cnt;
    mem_wdata      = FILL;

    if (state != ST_INIT && clash) contention_nxt = 1'b1;

    case (state)
      ST_INIT: begin
        // The counter wraps to 0 on the same edge that leaves INIT.
        mem_we    = nreset;
        sweep_nxt = sweep_cnt + 13'd1;
        if (sweep_cnt == 13'h1FFF) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (wr_cond) begin
          state_nxt   = ST_WRITE;
          wr_addr_nxt = ma;
          wr_data_nxt = md_in;
        end else if (rd_cond) begin
          state_nxt   = ST_READ;
          rd_addr_nxt = ma;
          lat_nxt     = 3'd1;
        end
      end
      ST_READ: begin
        if (wr_cond) begin
          state_nxt   = ST_WRITE;
          wr_addr_nxt = ma;
          wr_data_nxt = md_in;
        end else if (!rd_cond) begin
          state_nxt = ST_IDLE;
        end else if (ma != rd_addr) begin
          rd_addr_nxt = ma;
          lat_nxt     = 3'd1;
        end else if (lat_cnt == LAT) begin
          md_oe_nxt  = 1'b1;
          md_out_nxt = mem[rd_addr];
        end else begin
          lat_nxt = lat_cnt + 3'd1;
        end
      end
      ST_WRITE: begin
        if (wr_cond) begin
          wr_addr_nxt = ma;
          wr_data_nxt = md_in;
        end else begin
          // The last captured address and data are what was on the pins just before release.
          mem_we        = nreset;
          mem_addr      = wr_addr;
          mem_wdata     = wr_data;
          wr_commit_nxt = 1'b1;
          if (rd_cond) begin
            state_nxt   = ST_READ;
            rd_addr_nxt = ma;
            lat_nxt     = 3'd1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
